// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter with round-robin grant; sub-word stores are done
// as read-modify-write against a word-wide memory with a combinational read port.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [2:0]            req0_funct3,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [2:0]            req1_funct3,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(MEM_WORDS);

    state_t                state;
    logic                  prio;
    logic                  port_q;
    logic                  we_q;
    logic [1:0]            addr_lo_q;
    logic [2:0]            funct3_q;
    logic [15:0]           wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic                  grant_any;
    logic                  grant_port;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [2:0]            sel_funct3;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_err;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merge_val;

    // Unsupported size, misalignment or an address past the end of memory.
    function automatic logic req_error(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] f3);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = a[0];
            3'b010:         bad = (a[1:0] != 2'b00);
            default:        bad = 1'b1;
        endcase
        if ({2'b00, a[ADDR_WIDTH-1:2]} >= WORD_LIMIT) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // With both ports valid the priority bit picks; a lone valid port always wins.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_port = (req0_valid && req1_valid) ? prio : req1_valid;
        sel_we     = grant_port ? req1_we     : req0_we;
        sel_addr   = grant_port ? req1_addr   : req0_addr;
        sel_funct3 = grant_port ? req1_funct3 : req0_funct3;
        sel_wdata  = grant_port ? req1_wdata  : req0_wdata;
        sel_err    = req_error(sel_addr, sel_funct3);
    end

    always_comb begin
        byte_sel = mem_rd_data[{addr_lo_q, 3'b000} +: 8];
        half_sel = mem_rd_data[{addr_lo_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_val = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_val = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_val = mem_rd_data;
        endcase
        merge_val = mem_rd_data;
        if (!funct3_q[0]) begin
            merge_val[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_val[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prio       <= 1'b0;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_lo_q  <= 2'b00;
            funct3_q   <= 3'b000;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wr_data_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        prio      <= ~grant_port;
                        port_q    <= grant_port;
                        we_q      <= sel_we;
                        addr_lo_q <= sel_addr[1:0];
                        funct3_q  <= sel_funct3;
                        wdata_q   <= sel_wdata[15:0];
                        rdata_q   <= '0;
                        if (sel_err) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q      <= 1'b0;
                            wr_data_q  <= sel_wdata;
                            mem_addr_q <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_val;
                        state   <= RESP;
                    end else if (funct3_q == 3'b010) begin
                        state <= RESP;
                    end else begin
                        wr_data_q <= merge_val;
                        state     <= MERGE;
                    end
                end
                MERGE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates the strobes immediately so an abandoned merge never writes.
    assign req0_ready  = !reset && (state == IDLE) && grant_any && !grant_port;
    assign req1_ready  = !reset && (state == IDLE) && grant_any && grant_port;
    assign rsp0_valid  = !reset && (state == RESP) && !port_q;
    assign rsp1_valid  = !reset && (state == RESP) && port_q;
    assign rsp0_rdata  = rdata_q;
    assign rsp1_rdata  = rdata_q;
    assign rsp0_err    = err_q;
    assign rsp1_err    = err_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = wr_data_q;
    assign mem_wr_en   = !reset && ((state == MERGE) ||
                         ((state == ACCESS) && we_q && (funct3_q == 3'b010)));

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
 ADDR_WIDTH, 32, byte-address width;
 DATA_WIDTH, 32, word width;
 MEM_WORDS, 64, number of words in the attached data memory.
REQ-002 Ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock, rising edge;
 reset  in  1  synchronous, active-high reset;
 reqN_valid  in  1  request valid, N=0 (CPU), N=1 (loader/debug);
 reqN_ready  out  1  request accepted this cycle;
 reqN_we  in  1  1=store, 0=load;
 reqN_addr  in  ADDR_WIDTH  byte address;
 reqN_funct3  in  3  RISC-V size code: 000 b, 001 h, 010 w, 100 bu, 101 hu;
 reqN_wdata  in  DATA_WIDTH  store data, right-aligned;
 rspN_valid  out  1  one-cycle completion pulse;
 rspN_rdata  out  DATA_WIDTH  load result, extended;
 rspN_err  out  1  request rejected, no memory effect;
 mem_addr  out  ADDR_WIDTH  word-aligned byte address to memory (bits[1:0]=00);
 mem_wr_en  out  1  full-word write strobe;
 mem_wr_data  out  DATA_WIDTH  word written;
 mem_rd_data  in  DATA_WIDTH  combinational read of mem_addr.
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 FSM states IDLE, ACCESS, MERGE, RESP; one request in flight at a time.
REQ-005 In IDLE, at most one reqN_ready is high (combinational), granted to a valid port; reqN_ready is 0 in every other state.
REQ-006 Arbitration is round-robin: with both valid, grant the port not granted last; a single valid port is always granted; after reset port 0 has priority.
REQ-007 On the accept edge, the block latches port, we, addr, funct3 and wdata; requesters hold the request stable until ready.
REQ-008 Error check at accept: error if funct3 is not one of the five codes; halfword with addr[0]=1; word with addr[1:0]!=00; or addr[ADDR_WIDTH-1:2] >= MEM_WORDS. On error, go IDLE->RESP directly with err=1, rdata=0, no mem_wr_en.
REQ-009 ACCESS: mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}; the block latches mem_rd_data. Word store: mem_wr_en=1, mem_wr_data=wdata, next state RESP. Load: next state RESP. Byte/half store: next state MERGE.
REQ-010 MERGE: mem_wr_en=1; mem_wr_data = latched word with only the target lane(s) replaced by wdata[7:0] (lane addr[1:0]) or wdata[15:0] (lanes addr[1]*2 +1:0); other lanes unchanged. Next state RESP.
REQ-011 Load extraction: the byte/half is selected by addr[1:0]; funct3 000/001 sign-extend; 100/101 zero-extend; 010 returns the word.
REQ-012 RESP: rspN_valid=1 for exactly one cycle on the granted port only, with rdata (0 for stores) and err. Next state IDLE; a new grant is possible in the following cycle.
REQ-013 Latency from accept edge to rsp_valid: load or word store 2 cycles; sub-word store 3 cycles; error 1 cycle.
REQ-014 mem_wr_en is 0 in IDLE and RESP. mem_addr holds its last value when idle.

Reset
REQ-015 While reset=1: mem_wr_en=0, all reqN_ready=0, all rspN_valid=0 combinationally.
REQ-016 At the reset edge: state=IDLE, rspN_rdata=0, rspN_err=0, mem_wr_data=0, mem_addr=0, round-robin pointer selects port 0.
REQ-017 Reset in any state abandons the transaction with no memory write and no response.

Verification
REQ-018 Memory word 1 = 0x11223344. Port 0 sb, addr 0x5, wdata 0xAB -> MERGE writes 0x1122AB44; rsp0_valid 3 cycles after accept.
REQ-019 Word 2 = 0x0000_80F0. lb at 0x8 -> 0xFFFFFFF0; lbu at 0x8 -> 0x000000F0; lh at 0x8 -> 0xFFFF80F0; lhu at 0x8 -> 0x000080F0.
REQ-020 Both ports valid continuously, 4 transactions -> grants 0,1,0,1; each rsp only on its own port.
REQ-021 lw at 0x6, sh at 0x3, lw at 0x100 (MEM_WORDS=64), funct3=011 -> each gives rsp_err=1 after 1 cycle, rdata=0, mem_wr_en never high.
REQ-022 Reset asserted during MERGE of sb at 0x4 -> no mem_wr_en at that edge; word 1 unchanged; no rsp_valid; port 0 granted first after reset.
REQ-023 sw at 0x0C, wdata 0xDEADBEEF, then lw at 0x0C -> word 3 = 0xDEADBEEF and load returns 0xDEADBEEF; each completes 2 cycles after accept.
